// File: rtl/amba_memory_slave.sv
// AXI4-Lite-style word-addressed memory slave with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional build macro: AMBA_SLAVE_RANGE_CHECK_EN enables out-of-range SLVERR responses.
module amba_memory_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int READ_WAIT  = 0
) (
    input  logic        ACLK,
    input  logic        reset,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [1:0]  w_state_dbg,
    output logic [1:0]  r_state_dbg
);

    // Handshake rule on every channel: a transfer happens on the rising edge where VALID and
    // READY are both high; a VALID we drive stays high with stable payload until that edge.

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RESP = 2'd1
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    logic [31:0] mem [0:DEPTH-1];

    // Write channel state
    w_state_t    w_state, w_state_d;
    logic        aw_held, aw_held_d;
    logic        w_held, w_held_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        awready_d, wready_d, bvalid_d;
    logic [1:0]  bresp_d;

    // Read channel state
    r_state_t    r_state, r_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [3:0]  r_cnt, r_cnt_d;
    logic        arready_d, rvalid_d;
    logic [1:0]  rresp_d;
    logic [31:0] rdata_d;

    logic        aw_fire, w_fire, ar_fire;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_word;
    logic [3:0]  wr_strb;
    logic        wr_err, rd_err, mem_we;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    // A beat arriving this edge takes priority over the latched copy (which is empty then).
    assign wr_addr = aw_held ? aw_addr_q : AWADDR;
    assign wr_data = w_held  ? w_data_q  : WDATA;
    assign wr_strb = w_held  ? w_strb_q  : WSTRB;
    assign rd_addr = (r_state == R_IDLE) ? ARADDR : ar_addr_q;
    assign wr_idx  = wr_addr[ADDR_WIDTH-1:0];
    assign rd_idx  = rd_addr[ADDR_WIDTH-1:0];
    assign rd_word = mem[rd_idx];

`ifdef AMBA_SLAVE_RANGE_CHECK_EN
    assign wr_err = |wr_addr[31:ADDR_WIDTH];
    assign rd_err = |rd_addr[31:ADDR_WIDTH];
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    wire unused_ok = &{1'b0, AWPROT, ARPROT, wr_addr[31:ADDR_WIDTH], rd_addr[31:ADDR_WIDTH]};

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    always_comb begin
        w_state_d = w_state;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = AWREADY;
        wready_d  = WREADY;
        bvalid_d  = BVALID;
        bresp_d   = BRESP;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = AWADDR;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    w_data_d = WDATA;
                    w_strb_d = WSTRB;
                end
                awready_d = !(aw_held || aw_fire);
                wready_d  = !(w_held || w_fire);
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    mem_we    = !wr_err;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state;
        ar_addr_d = ar_addr_q;
        r_cnt_d   = r_cnt;
        arready_d = ARREADY;
        rvalid_d  = RVALID;
        rresp_d   = RRESP;
        rdata_d   = RDATA;
        case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    ar_addr_d = ARADDR;
                    arready_d = 1'b0;
                    if (READ_WAIT == 0) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = rd_err ? 32'h0 : rd_word;
                        rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_state_d = R_DATA;
                    end else begin
                        r_cnt_d   = 4'(READ_WAIT - 1);
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 4'd0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_err ? 32'h0 : rd_word;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt - 4'd1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge reset) begin
        if (!reset) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= 32'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            r_state   <= R_IDLE;
            ar_addr_q <= 32'h0;
            r_cnt     <= 4'h0;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RRESP     <= RESP_OKAY;
            RDATA     <= 32'h0;
        end else begin
            w_state   <= w_state_d;
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            AWREADY   <= awready_d;
            WREADY    <= wready_d;
            BVALID    <= bvalid_d;
            BRESP     <= bresp_d;
            r_state   <= r_state_d;
            ar_addr_q <= ar_addr_d;
            r_cnt     <= r_cnt_d;
            ARREADY   <= arready_d;
            RVALID    <= rvalid_d;
            RRESP     <= rresp_d;
            RDATA     <= rdata_d;
        end
    end

    // Memory is not reset; a read sampled on the commit edge sees the old word.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_amba_memory_slave.sv
// Self-checking bench for amba_memory_slave (ADDR_WIDTH=10, READ_WAIT=3) with a word model and
// response queues; expectations follow AMBA_SLAVE_RANGE_CHECK_EN when it is defined.
module tb_amba_memory_slave;

    localparam int AW = 10;
    localparam int RW = 3;
`ifdef AMBA_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [2:0]  AWPROT = '0, ARPROT = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP, w_state_dbg, r_state_dbg;
    logic [31:0] RDATA;

    amba_memory_slave #(.ADDR_WIDTH(AW), .READ_WAIT(RW)) dut (
        .ACLK(ACLK), .reset(reset),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    // clock / watchdog
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] model [0:(1<<AW)-1];
    logic [33:0] exp_q[$];
    logic [1:0]  bexp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, want);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return RANGE_EN & (|a[31:AW]);
    endfunction

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return a[AW-1:0];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!addr_err(a)) begin
            for (int i = 0; i < 4; i++) if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // driver: W leads AW by w_lead cycles; BREADY held low for b_hold cycles once BVALID is up
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int b_hold);
        bit aw_pend, w_pend, hs_aw, hs_w;
        int cyc;
        logic [1:0] eb;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        cyc     = 0;
        bexp_q.push_back(addr_err(a) ? 2'b10 : 2'b00);
        model_write(a, d, s);
        AWADDR = a; WDATA = d; WSTRB = s;
        while ((aw_pend || w_pend) && cyc < 50) begin
            AWVALID = aw_pend && (cyc >= w_lead);
            WVALID  = w_pend;
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(negedge ACLK);
            if (hs_aw) aw_pend = 1'b0;
            if (hs_w)  w_pend  = 1'b0;
            if (hs_w && aw_pend) begin
                check("wready_drop", 32'(WREADY), 32'd0);
                check("awready_hold", 32'(AWREADY), 32'd1);
            end
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("write_accept", 32'({aw_pend, w_pend}), 32'd0);
        check("bvalid_lat", 32'(BVALID), 32'd1);
        eb = bexp_q.pop_front();
        repeat (b_hold) begin
            @(negedge ACLK);
            check("bvalid_hold", 32'(BVALID), 32'd1);
            check("bresp_hold", 32'(BRESP), 32'(eb));
        end
        check("bresp", 32'(BRESP), 32'(eb));
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bvalid_clr", 32'(BVALID), 32'd0);
        check("aw_w_ready_b2b", 32'({AWREADY, WREADY}), 32'd3);
    endtask

    // driver: RREADY held low for r_hold cycles once RVALID is up
    task automatic do_read(input logic [31:0] a, input int r_hold);
        logic [33:0] e;
        int lat;
        exp_q.push_back(addr_err(a) ? {2'b10, 32'h0} : {2'b00, model[widx(a)]});
        ARADDR  = a;
        ARVALID = 1'b1;
        check("arready_idle", 32'(ARREADY), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("arready_drop", 32'(ARREADY), 32'd0);
        lat = 1;
        while (!RVALID && lat < 40) begin
            @(negedge ACLK);
            lat++;
        end
        check("rvalid_lat", 32'(lat), 32'(RW + 1));
        e = exp_q.pop_front();
        check("rdata", RDATA, e[31:0]);
        check("rresp", 32'(RRESP), 32'(e[33:32]));
        repeat (r_hold) begin
            @(negedge ACLK);
            check("rvalid_hold", 32'(RVALID), 32'd1);
            check("rdata_hold", RDATA, e[31:0]);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("rvalid_clr", 32'(RVALID), 32'd0);
        check("arready_b2b", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        logic [33:0] e;
        logic [1:0]  eb;
        logic [31:0] a;

        // reset values
        repeat (3) @(negedge ACLK);
        check("rst_readys", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
        check("rst_valids", 32'({BVALID, RVALID}), 32'd0);
        check("rst_resps", 32'({BRESP, RRESP}), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        reset = 1'b1;
        @(negedge ACLK);
        check("readys_after_rst", 32'({AWREADY, WREADY, ARREADY}), 32'd7);

        // basic write/read, AW and W together
        do_write(32'd5, 32'hDEADBEEF, 4'hF, 0, 0);
        do_read(32'd5, 0);

        // W three cycles ahead of AW, byte-lane merge
        do_write(32'd9, 32'h11223344, 4'hF, 0, 0);
        do_write(32'd9, 32'h0000AA00, 4'b0010, 3, 2);
        do_read(32'd9, 0);
        check("strb_merge_model", model[9], 32'h1122AA44);

        // RREADY held low, data stable
        do_read(32'd5, 4);

        // empty strobe leaves the word alone
        do_write(32'd5, 32'hFFFFFFFF, 4'h0, 0, 1);
        do_read(32'd5, 0);

        // same-edge commit and sample of word 7
        do_write(32'd7, 32'h9, 4'hF, 0, 0);
        exp_q.push_back({2'b00, model[7]});
        ARADDR  = 32'd7;
        ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        repeat (RW - 1) @(negedge ACLK);
        AWADDR = 32'd7; WDATA = 32'h5; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        bexp_q.push_back(2'b00);
        model_write(32'd7, 32'h5, 4'hF);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        check("coll_rvalid", 32'(RVALID), 32'd1);
        check("coll_bvalid", 32'(BVALID), 32'd1);
        e  = exp_q.pop_front();
        eb = bexp_q.pop_front();
        check("coll_rdata_old", RDATA, e[31:0]);
        check("coll_bresp", 32'(BRESP), 32'(eb));
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0; BREADY = 1'b0;
        do_read(32'd7, 0);

        // out-of-range address: SLVERR with range check, alias of word 0 otherwise
        do_write(32'd0, 32'h0BADCAFE, 4'hF, 0, 0);
        do_write(32'h400, 32'hCAFEF00D, 4'hF, 0, 0);
        do_read(32'h400, 0);
        do_read(32'd0, 0);

        // random traffic on words 16..31
        for (int i = 0; i < 6; i++) begin
            a = 32'(16 + $urandom_range(0, 15));
            do_write(a, $urandom, 4'hF, 0, 0);
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 1));
            do_read(a, $urandom_range(0, 2));
        end

        // reset while RVALID is up and a lone W beat is latched
        do_write(32'd20, 32'hA5A5A5A5, 4'hF, 0, 0);
        do_write(32'd21, 32'h5A5A5A5A, 4'hF, 0, 0);
        exp_q.push_back({2'b00, model[20]});
        ARADDR  = 32'd20;
        ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        repeat (RW) @(negedge ACLK);
        check("rvalid_pre_rst", 32'(RVALID), 32'd1);
        WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        check("w_latched", 32'(WREADY), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 32'd0);
        check("rst_mid_rdata", RDATA, 32'd0);
        exp_q.delete();
        @(negedge ACLK);
        @(negedge ACLK);
        check("rst_hold_ctrl", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 32'd0);
        reset = 1'b1;
        @(negedge ACLK);
        check("readys_after_rel", 32'({AWREADY, WREADY, ARREADY}), 32'd7);
        AWADDR = 32'd21; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        check("no_stale_w_bvalid", 32'(BVALID), 32'd0);
        check("no_stale_w_wready", 32'(WREADY), 32'd1);
        do_read(32'd21, 0);
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        bexp_q.push_back(2'b00);
        model_write(32'd21, 32'h12345678, 4'hF);
        @(negedge ACLK);
        WVALID = 1'b0;
        check("late_w_bvalid", 32'(BVALID), 32'd1);
        eb = bexp_q.pop_front();
        check("late_w_bresp", 32'(BRESP), 32'(eb));
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        do_read(32'd21, 0);
        do_read(32'd20, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amba_memory_slave.md
# amba_memory_slave

AXI4-Lite-style word-addressed memory responder: the slave end of the bus that the CPU's memory master drives. Accepts independent write (AW/W/B) and read (AR/R) transactions, stores data in an internal word array with byte-strobe writes, and returns OKAY/SLVERR responses. Sits on the testbench/SoC side of the CPU's AMBA ports, directly replacing an external memory model.

## Interface
- ADDR_WIDTH, 10: word-index width; memory depth = 2**ADDR_WIDTH 32-bit words.
- READ_WAIT, 0: extra wait cycles (0..15) between AR handshake and RVALID.
- ACLK  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all control state, not memory contents.
- AWADDR  in  32  write word address (word-addressed; bit 0 = word 0/1).
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables; WSTRB[i] writes WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts response.
- ARADDR  in  32  read word address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  32  read data.
- RRESP  out  2  read response, same encoding as BRESP.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts read data.

## Operation
- All outputs registered. Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0. Readys go to 1 on first ACLK edge after reset deasserts.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - W_IDLE: AW and W latched independently, any order or same cycle; AWREADY drops on the edge AW is latched, WREADY on the edge W is latched.
  - On the edge both are held, memory commits (strobed) and FSM enters W_RESP with BVALID=1, BRESP set.
  - W_RESP: BVALID, BRESP stable until BREADY; on handshake edge BVALID=0, AWREADY=WREADY=1, back to W_IDLE.
- Read FSM: R_IDLE -> R_WAIT (skipped if READ_WAIT=0) -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1; on handshake latch address, ARREADY=0, load wait counter.
  - R_WAIT: decrement counter each cycle; at zero sample memory into RDATA, set RRESP, RVALID=1.
  - R_DATA: RDATA/RRESP/RVALID stable until RREADY; handshake edge -> RVALID=0, ARREADY=1.
- Read and write channels fully independent; both may be active simultaneously.
- Same-edge collision (write commit and read sample to same word): read returns pre-write data.
- WSTRB=4'b0000: handshake completes, memory unchanged, BRESP=OKAY.
- reset asserted mid-transaction: both FSMs abort to idle immediately, pending latched AW/W/AR discarded, outputs to reset values; memory retains completed writes.

## Timing
- Write: AW and W latched by edge N -> BVALID visible cycle N+1; minimum 1 cycle from final handshake to response.
- Read: AR handshake edge N -> RVALID visible cycle N+1+READ_WAIT.
- Back-to-back: after B (or R) handshake edge M, AWREADY/WREADY (or ARREADY) high in cycle M+1; one transaction per channel outstanding; throughput 1 write per 2 cycles, 1 read per 2+READ_WAIT cycles.
- VALID outputs never drop without the matching READY.

## Configuration
- AMBA_SLAVE_RANGE_CHECK_EN defined: addresses with any bit above ADDR_WIDTH-1 set are out of range; writes suppressed with BRESP=SLVERR, reads return RDATA=0 with RRESP=SLVERR.
- Undefined: upper address bits ignored (address wraps modulo depth); responses always OKAY.

## Test plan
- Write 0xDEADBEEF to word 5 with AW and W in same cycle, WSTRB=4'hF, BREADY=1 -> BVALID one cycle later, BRESP=00; read word 5 -> RDATA=0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW, then WSTRB=4'b0010 writes 0x0000AA00 over 0x11223344 -> word reads 0x1122AA44.
- READ_WAIT=3, AR handshake at edge N, RREADY held low 4 cycles -> RVALID rises in cycle N+4, RDATA stable until RREADY handshake, ARREADY high next cycle.
- Same-edge write commit of 0x5 and read sample of word 7 (previously 0x9) -> RDATA=0x9; subsequent read -> 0x5.
- With AMBA_SLAVE_RANGE_CHECK_EN, ADDR_WIDTH=10: write/read address 0x400 -> BRESP=RRESP=2'b10, RDATA=0, word 0 unchanged; without macro, 0x400 aliases word 0, OKAY.
- reset asserted while RVALID=1 and W latched -> all VALID/READY 0 during reset, readys 1 one edge after release, no write committed.
